exe_result_fifo: RTL and testbench

- Downstream stage of the execution unit: captures each result word and its 4-bit status, buffers them in a small FIFO and presents them to the consumer through a valid/ready handshake.
- Keeps saturating event counters so software can read error and overflow statistics without polling every result:
  - results flagged ERROR
  - results flagged OVF
  - results dropped because the FIFO was full
- Input side is driven directly by the execution unit's result/status outputs plus a producer-supplied valid. The producer delays its issue strobe by one cycle to match the execution unit's register stage.

---
 rtl/exe_result_fifo.sv | 122 ++++++++++++
 tb/tb_exe_result_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_result_fifo.sv
// exe_result_fifo
//   Buffers execution-unit results (data word + 4-bit status) in a small
//   show-ahead FIFO. Results leave through a valid/ready handshake.
//   Saturating counters record how many accepted results were flagged
//   ERROR or OVF, and how many results were dropped because the FIFO was full.
//
// Ports
//   i_clk, i_rst         clock (rising edge); synchronous active-low reset
//   in_data, in_status   result word and status from the execution unit
//   in_valid / o_ready   producer handshake (o_ready = !full)
//   o_data, o_status     head entry, forced to 0 while empty
//   o_valid / in_ready   consumer handshake (o_valid = !empty)
//   o_level              number of stored entries, 0..DEPTH
//   o_err_cnt            accepted entries with status[ERROR_BIT]
//   o_ovf_cnt            accepted entries with status[OVF_BIT]
//   o_drop_cnt           cycles with in_valid while full

`ifndef OVF_BIT
`define OVF_BIT 0
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 1
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 2
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 3
`endif

module exe_result_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [BITS-1:0]            in_data,
    input  logic [3:0]                 in_status,
    input  logic                       in_valid,
    output logic                       o_ready,
    output logic [BITS-1:0]            o_data,
    output logic [3:0]                 o_status,
    output logic                       o_valid,
    input  logic                       in_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic [CNT_W-1:0]           o_ovf_cnt,
    output logic [CNT_W-1:0]           o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [3:0]      status;
        logic [BITS-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [LW-1:0]   level;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic            rd_en;

    // Handshake flags come from the level register only, so neither
    // in_valid nor in_ready reaches an output combinationally.
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO refuses the write even if the head is popped in the same
    // cycle; the freed slot is usable from the next cycle.
    assign wr_en = in_valid && !full;
    assign rd_en = in_ready && !empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage has no reset; stale contents are hidden by the empty mask.
    always_ff @(posedge i_clk) begin
        if (i_rst && wr_en) begin
            mem[wptr] <= '{status: in_status, data: in_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_err_cnt  <= '0;
            o_ovf_cnt  <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (wr_en && in_status[`ERROR_BIT] && (o_err_cnt != '1))
                o_err_cnt <= o_err_cnt + 1'b1;
            if (wr_en && in_status[`OVF_BIT] && (o_ovf_cnt != '1))
                o_ovf_cnt <= o_ovf_cnt + 1'b1;
            if (in_valid && full && (o_drop_cnt != '1))
                o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    assign o_ready  = !full;
    assign o_valid  = !empty;
    assign o_level  = level;
    assign o_data   = empty ? '0 : mem[rptr].data;
    assign o_status = empty ? '0 : mem[rptr].status;

endmodule

// File: tb/tb_exe_result_fifo.sv
// Bench for exe_result_fifo: two instances (CNT_W=8 and CNT_W=4) share the
// same stimulus. A queue-based model tracks what the FIFO must hold, and a
// negedge process compares both instances against it every cycle. Directed
// steps add literal expectations, then randomized traffic follows.

`ifndef OVF_BIT
`define OVF_BIT 0
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 1
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 2
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 3
`endif

module tb_exe_result_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [3:0] in_status;
    logic       in_valid;
    logic       in_ready;

    logic       a_ready, a_valid, b_ready, b_valid;
    logic [7:0] a_data, b_data;
    logic [3:0] a_status, b_status;
    logic [2:0] a_level, b_level;
    logic [7:0] a_err, a_ovf, a_drop;
    logic [3:0] b_err, b_ovf, b_drop;

    always #5 clk = ~clk;

    exe_result_fifo #(.BITS(8), .DEPTH(DEPTH), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .in_data(in_data), .in_status(in_status),
        .in_valid(in_valid), .o_ready(a_ready), .o_data(a_data),
        .o_status(a_status), .o_valid(a_valid), .in_ready(in_ready),
        .o_level(a_level), .o_err_cnt(a_err), .o_ovf_cnt(a_ovf),
        .o_drop_cnt(a_drop)
    );

    exe_result_fifo #(.BITS(8), .DEPTH(DEPTH), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .in_data(in_data), .in_status(in_status),
        .in_valid(in_valid), .o_ready(b_ready), .o_data(b_data),
        .o_status(b_status), .o_valid(b_valid), .in_ready(in_ready),
        .o_level(b_level), .o_err_cnt(b_err), .o_ovf_cnt(b_ovf),
        .o_drop_cnt(b_drop)
    );

    // Model: queue of {status, data} plus unbounded event totals.
    logic [11:0] q[$];
    int err_n, ovf_n, drop_n;
    int checks, failures;
    bit chk_en;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int n, int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_update();
        bit was_full, was_empty;
        if (!rst) begin
            q.delete();
            err_n = 0; ovf_n = 0; drop_n = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (in_valid && was_full) drop_n++;
            if (in_ready && !was_empty) void'(q.pop_front());
            if (in_valid && !was_full) begin
                q.push_back({in_status, in_data});
                if (in_status[`ERROR_BIT]) err_n++;
                if (in_status[`OVF_BIT])   ovf_n++;
            end
        end
    endtask

    task automatic step(bit r, bit v, logic [7:0] d, logic [3:0] s, bit rd);
        rst = r; in_valid = v; in_data = d; in_status = s; in_ready = rd;
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] head;
            int n;
            n    = q.size();
            head = (n != 0) ? q[0] : 12'h000;
            check("a_valid",  a_valid,  n != 0);
            check("a_ready",  a_ready,  n != DEPTH);
            check("a_level",  a_level,  n);
            check("a_data",   a_data,   head[7:0]);
            check("a_status", a_status, head[11:8]);
            check("a_err",    a_err,    sat(err_n, 8));
            check("a_ovf",    a_ovf,    sat(ovf_n, 8));
            check("a_drop",   a_drop,   sat(drop_n, 8));
            check("b_valid",  b_valid,  n != 0);
            check("b_ready",  b_ready,  n != DEPTH);
            check("b_level",  b_level,  n);
            check("b_data",   b_data,   head[7:0]);
            check("b_status", b_status, head[11:8]);
            check("b_err",    b_err,    sat(err_n, 4));
            check("b_ovf",    b_ovf,    sat(ovf_n, 4));
            check("b_drop",   b_drop,   sat(drop_n, 4));
        end
    end

    localparam logic [3:0] ST_ERR = 4'(1 << `ERROR_BIT);
    localparam logic [3:0] ST_OVF = 4'(1 << `OVF_BIT);

    initial begin
        checks = 0; failures = 0; chk_en = 0;
        err_n = 0; ovf_n = 0; drop_n = 0;

        // Reset, then idle with in_ready high.
        step(0, 0, 8'h00, 4'h0, 0);
        step(0, 0, 8'h00, 4'h0, 0);
        chk_en = 1;
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 4'h0, 1);
        check("rst_valid", a_valid, 0);
        check("rst_ready", a_ready, 1);
        check("rst_level", a_level, 0);
        check("rst_err",   a_err,   0);
        check("rst_drop",  b_drop,  0);

        // Single word with ERROR flag, held, then popped.
        step(1, 1, 8'hA5, ST_ERR, 0);
        check("single_valid", a_valid, 1);
        check("single_data",  a_data,  8'hA5);
        check("single_level", a_level, 1);
        check("single_err",   a_err,   1);
        check("single_ovf",   a_ovf,   0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 4'h0, 0);
        check("hold_data",  a_data,   8'hA5);
        check("hold_stat",  a_status, ST_ERR);
        step(1, 0, 8'h00, 4'h0, 1);
        check("pop_valid", a_valid, 0);
        check("pop_level", a_level, 0);

        // Fill to full, fifth write dropped.
        for (int i = 1; i <= 5; i++) step(1, 1, 8'(i), 4'h0, 0);
        check("full_ready", a_ready, 0);
        check("full_level", a_level, 4);
        check("full_drop",  a_drop,  1);
        check("full_head",  a_data,  8'h01);

        // Full with simultaneous read and write: write refused.
        step(1, 1, 8'h06, 4'h0, 1);
        check("fullrw_level", a_level, 3);
        check("fullrw_drop",  a_drop,  2);
        check("fullrw_head",  a_data,  8'h02);
        step(1, 1, 8'h06, 4'h0, 0);
        check("refill_level", a_level, 4);

        // Drain: 02, 03, 04, 06 in order.
        begin
            logic [7:0] exp_seq [4];
            exp_seq = '{8'h02, 8'h03, 8'h04, 8'h06};
            for (int i = 0; i < 4; i++) begin
                check("drain_data", a_data, exp_seq[i]);
                step(1, 0, 8'h00, 4'h0, 1);
            end
        end
        check("drain_valid", a_valid, 0);

        // Streaming: level stays at 1, head follows the input one cycle late.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(i), 4'h0, 1);
            check("stream_level", a_level, 1);
            check("stream_data",  a_data,  i);
        end

        // Saturation: 20 accepted OVF writes.
        for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h40 + i), ST_OVF, 1);
        check("sat_ovf_b", b_ovf, 15);
        check("sat_ovf_a", a_ovf, 20);
        check("sat_err_a", a_err, 1);
        step(1, 0, 8'h00, 4'h0, 1);

        // Reset with three entries stored.
        for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h80 + i), ST_ERR | ST_OVF, 0);
        check("mid_level", a_level, 3);
        step(0, 1, 8'hFF, 4'hF, 1);
        check("midrst_level", a_level, 0);
        check("midrst_valid", b_valid, 0);
        check("midrst_ovf",   b_ovf,   0);
        check("midrst_err",   a_err,   0);
        check("midrst_drop",  a_drop,  0);

        // Randomized traffic in phases of differing pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int pv, pr;
            pv = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 20;
            pr = (ph % 2 == 0) ? 30 : 80;
            for (int n = 0; n < 250; n++) begin
                step($urandom_range(0, 199) != 0,
                     $urandom_range(0, 99) < pv,
                     8'($urandom),
                     4'($urandom),
                     $urandom_range(0, 99) < pr);
            end
        end

        chk_en = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
